// File: rtl/cpu_defs.sv
// -----------------------------------------------------------------------------
// cpu_defs
//   Definitions shared by the fetch stage and its branch predictor: reset PC,
//   NOP / HLT encodings, 2-bit branch-history counter encodings with their
//   saturating update, and the IF/ID pipeline register layout.
// -----------------------------------------------------------------------------
package cpu_defs;

    localparam logic [15:0] RST_PC   = 16'h0000;
    localparam logic [15:0] NOP_INST = 16'h0000;
    localparam logic [3:0]  OPC_HLT  = 4'hF;

    // 2-bit branch-history counter states; bit 1 is the taken prediction.
    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } bht_ctr_e;

    // Saturating counter step: 00..11, never wraps.
    function automatic logic [1:0] bht_next(input logic [1:0] ctr, input logic taken);
        logic [1:0] nxt;
        if (taken) begin
            nxt = (ctr == ST)  ? ST  : ctr + 2'b01;
        end else begin
            nxt = (ctr == SNT) ? SNT : ctr - 2'b01;
        end
        return nxt;
    endfunction

    // IF/ID pipeline register contents.
    typedef struct packed {
        logic [15:0] inst;
        logic [15:0] pc_curr;
        logic [15:0] pc_next;
        logic        pred_taken;
        logic [15:0] pred_target;
    } if_id_t;

endpackage

// File: rtl/branch_predictor.sv
// -----------------------------------------------------------------------------
// branch_predictor
//   Direct-mapped 2-bit BHT plus tagged BTB, 2**IDX_W entries indexed by
//   pc[IDX_W:1]. The lookup port is purely combinational; the train port
//   writes on the rising clock edge, so a same-cycle lookup of the index being
//   trained sees the pre-edge contents.
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   lookup_pc         PC being fetched
//   pred_taken        tag hit and counter in a taken state
//   pred_target       BTB target when predicted taken, else lookup_pc + 2
//   train_pc          PC (bits 15:1) of the branch being resolved
//   train_bht         step the counter toward train_taken
//   train_btb         write target/tag and mark entry valid
//   train_taken       resolved direction
//   train_target      resolved branch target
// -----------------------------------------------------------------------------
module branch_predictor
    import cpu_defs::*;
#(
    parameter int IDX_W = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] lookup_pc,
    output logic        pred_taken,
    output logic [15:0] pred_target,
    input  logic [15:1] train_pc,
    input  logic        train_bht,
    input  logic        train_btb,
    input  logic        train_taken,
    input  logic [15:0] train_target
);

    localparam int ENTRIES = 2 ** IDX_W;
    localparam int TAG_W   = 16 - IDX_W - 1;

    logic [1:0]       bht_q    [ENTRIES];
    logic             valid_q  [ENTRIES];
    logic [TAG_W-1:0] tag_q    [ENTRIES];
    logic [15:0]      target_q [ENTRIES];

    logic [IDX_W-1:0] lookup_idx;
    logic [TAG_W-1:0] lookup_tag;
    logic [IDX_W-1:0] train_idx;
    logic [TAG_W-1:0] train_tag;
    logic             hit;

    assign lookup_idx = lookup_pc[IDX_W:1];
    assign lookup_tag = lookup_pc[15:IDX_W+1];
    assign train_idx  = train_pc[IDX_W:1];
    assign train_tag  = train_pc[15:IDX_W+1];

    assign hit         = valid_q[lookup_idx] && (tag_q[lookup_idx] == lookup_tag);
    assign pred_taken  = hit && bht_q[lookup_idx][1];
    // PC + 2 wraps naturally at 16 bits (FFFE -> 0000).
    assign pred_target = pred_taken ? target_q[lookup_idx] : lookup_pc + 16'd2;

    // NOTE: non-blocking assignments for all clocked state so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                bht_q[i]   <= WNT;
                valid_q[i] <= 1'b0;
            end
        end else begin
            if (train_bht) begin
                bht_q[train_idx] <= bht_next(bht_q[train_idx], train_taken);
            end
            if (train_btb) begin
                valid_q[train_idx] <= 1'b1;
            end
        end
    end

    // NOTE: tag/target arrays are deliberately left unreset; valid_q gates
    // every use, so clearing them would only cost reset fan-out.
    always_ff @(posedge clk) begin
        if (train_btb) begin
            tag_q[train_idx]    <= train_tag;
            target_q[train_idx] <= train_target;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//   Instruction fetch with dynamic branch prediction and the IF/ID register.
//   Holds the PC, presents it to instruction memory, chooses the next PC
//   (stall > redirect > HLT hold > prediction) and trains the predictor with
//   decode's resolution of the branch currently in ID.
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   stall                      hold PC and IF/ID, suppress training
//   imem_addr / imem_data      instruction memory address (= PC) / word
//   actual_taken               branch in ID resolved taken
//   branch_target              resolved target of branch in ID
//   wen_BTB / wen_BHT          train BTB / BHT for branch in ID
//   update_PC                  mispredict: redirect PC and flush IF/ID
//   IF_ID_*                    registered instruction, its PC, PC+2,
//                              prediction and predicted next PC
// -----------------------------------------------------------------------------
module fetch_stage
    import cpu_defs::NOP_INST;
    import cpu_defs::OPC_HLT;
    import cpu_defs::if_id_t;
#(
    parameter int          IDX_W  = 4,
    parameter logic [15:0] RST_PC = cpu_defs::RST_PC
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_data,
    input  logic        actual_taken,
    input  logic [15:0] branch_target,
    input  logic        wen_BTB,
    input  logic        wen_BHT,
    input  logic        update_PC,
    output logic [15:0] IF_ID_pc_inst,
    output logic [15:0] IF_ID_pc_curr,
    output logic [15:0] IF_ID_pc_next,
    output logic        IF_ID_predicted_taken,
    output logic [15:0] IF_ID_predicted_target
);

    logic [15:0] pc_q;
    logic [15:0] pc_d;
    if_id_t      if_id_q;
    if_id_t      if_id_d;
    logic        pred_taken;
    logic [15:0] pred_target;
    logic        is_hlt;

    branch_predictor #(
        .IDX_W(IDX_W)
    ) u_bp (
        .clk          (clk),
        .rst_n        (rst_n),
        .lookup_pc    (pc_q),
        .pred_taken   (pred_taken),
        .pred_target  (pred_target),
        .train_pc     (if_id_q.pc_curr[15:1]),
        .train_bht    (wen_BHT && !stall),
        .train_btb    (wen_BTB && !stall),
        .train_taken  (actual_taken),
        .train_target (branch_target)
    );

    assign is_hlt = (imem_data[15:12] == OPC_HLT);

    // NOTE: every output of this block gets a hold default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        pc_d    = pc_q;
        if_id_d = if_id_q;
        if (!stall) begin
            if (update_PC) begin
                // Not-taken redirect resumes at the fall-through of the branch in ID.
                pc_d    = actual_taken ? branch_target : if_id_q.pc_next;
                if_id_d = '0;
                if_id_d.inst = NOP_INST;
            end else begin
                // HLT keeps re-fetching itself; decode stops on it.
                pc_d    = is_hlt ? pc_q : pred_target;
                if_id_d = '{
                    inst:        imem_data,
                    pc_curr:     pc_q,
                    pc_next:     pc_q + 16'd2,
                    pred_taken:  pred_taken,
                    pred_target: pred_target
                };
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= RST_PC;
            if_id_q <= '0;
        end else begin
            pc_q    <= pc_d;
            if_id_q <= if_id_d;
        end
    end

    assign imem_addr              = pc_q;
    assign IF_ID_pc_inst          = if_id_q.inst;
    assign IF_ID_pc_curr          = if_id_q.pc_curr;
    assign IF_ID_pc_next          = if_id_q.pc_next;
    assign IF_ID_predicted_taken  = if_id_q.pred_taken;
    assign IF_ID_predicted_target = if_id_q.pred_target;

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
//   Self-checking bench for fetch_stage. A cycle-level reference model of the
//   PC, IF/ID register and predictor computes the expected post-edge state
//   each cycle, pushes it to a scoreboard queue, and the entry is popped and
//   compared against the DUT one time unit after the edge. Directed checks
//   anchor the scenarios with literal expected values.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic [15:0] imem_addr;
    logic [15:0] imem_data;
    logic        actual_taken;
    logic [15:0] branch_target;
    logic        wen_BTB;
    logic        wen_BHT;
    logic        update_PC;
    logic [15:0] IF_ID_pc_inst;
    logic [15:0] IF_ID_pc_curr;
    logic [15:0] IF_ID_pc_next;
    logic        IF_ID_predicted_taken;
    logic [15:0] IF_ID_predicted_target;

    int n_checks = 0;
    int n_errors = 0;

    fetch_stage #(
        .IDX_W (4),
        .RST_PC(16'h0000)
    ) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .stall                 (stall),
        .imem_addr             (imem_addr),
        .imem_data             (imem_data),
        .actual_taken          (actual_taken),
        .branch_target         (branch_target),
        .wen_BTB               (wen_BTB),
        .wen_BHT               (wen_BHT),
        .update_PC             (update_PC),
        .IF_ID_pc_inst         (IF_ID_pc_inst),
        .IF_ID_pc_curr         (IF_ID_pc_curr),
        .IF_ID_pc_next         (IF_ID_pc_next),
        .IF_ID_predicted_taken (IF_ID_predicted_taken),
        .IF_ID_predicted_target(IF_ID_predicted_target)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory: one HLT at hlt_addr, distinct non-branch words elsewhere.
    logic [15:0] hlt_addr;
    always_comb imem_data = (imem_addr == hlt_addr) ? 16'hF000 : {4'h1, imem_addr[11:0]};

    // ---------------- reference model ----------------
    logic [15:0] m_pc, m_inst, m_curr, m_next, m_ptgt;
    logic        m_pt;
    logic [1:0]  m_bht   [16];
    logic [15:0] m_btb   [16];
    logic [10:0] m_tag   [16];
    logic        m_valid [16];

    typedef struct {
        logic [15:0] pc;
        logic [15:0] inst;
        logic [15:0] curr;
        logic [15:0] nxt;
        logic        pt;
        logic [15:0] ptgt;
    } exp_t;

    exp_t sb[$];

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = 16'h0000; m_inst = 16'h0; m_curr = 16'h0; m_next = 16'h0;
        m_pt = 1'b0; m_ptgt = 16'h0;
        for (int i = 0; i < 16; i++) begin
            m_bht[i] = 2'b01; m_valid[i] = 1'b0; m_btb[i] = 16'h0; m_tag[i] = 11'h0;
        end
    endtask

    // One clock: drive inputs, run the model, push expectation, clock, pop & compare.
    task automatic cycle(input logic s, input logic u, input logic at,
                         input logic [15:0] tgt, input logic wb, input logic wh);
        logic [15:0] word, ptgt, npc;
        logic [3:0]  li, ti;
        logic        hit, pt;
        exp_t        e;
        exp_t        got;

        stall = s; update_PC = u; actual_taken = at; branch_target = tgt;
        wen_BTB = wb; wen_BHT = wh;

        word = (m_pc == hlt_addr) ? 16'hF000 : {4'h1, m_pc[11:0]};
        li   = m_pc[4:1];
        hit  = m_valid[li] && (m_tag[li] == m_pc[15:5]);
        pt   = hit && m_bht[li][1];
        ptgt = pt ? m_btb[li] : m_pc + 16'd2;

        e = '{pc: m_pc, inst: m_inst, curr: m_curr, nxt: m_next, pt: m_pt, ptgt: m_ptgt};
        if (!s) begin
            ti = m_curr[4:1];
            if (wh) begin
                if (at) m_bht[ti] = (m_bht[ti] == 2'b11) ? 2'b11 : m_bht[ti] + 2'b01;
                else    m_bht[ti] = (m_bht[ti] == 2'b00) ? 2'b00 : m_bht[ti] - 2'b01;
            end
            if (wb) begin
                m_btb[ti] = tgt; m_tag[ti] = m_curr[15:5]; m_valid[ti] = 1'b1;
            end
            if (u) begin
                npc = at ? tgt : m_next;
                e = '{pc: npc, inst: 16'h0, curr: 16'h0, nxt: 16'h0, pt: 1'b0, ptgt: 16'h0};
            end else begin
                npc = (word[15:12] == 4'hF) ? m_pc : ptgt;
                e = '{pc: npc, inst: word, curr: m_pc, nxt: m_pc + 16'd2, pt: pt, ptgt: ptgt};
            end
        end
        m_pc = e.pc; m_inst = e.inst; m_curr = e.curr; m_next = e.nxt; m_pt = e.pt; m_ptgt = e.ptgt;
        sb.push_back(e);

        @(posedge clk);
        #1;
        got = sb.pop_front();
        check("sb_imem_addr",   imem_addr,                      got.pc);
        check("sb_inst",        IF_ID_pc_inst,                  got.inst);
        check("sb_pc_curr",     IF_ID_pc_curr,                  got.curr);
        check("sb_pc_next",     IF_ID_pc_next,                  got.nxt);
        check("sb_pred_taken",  {15'h0, IF_ID_predicted_taken}, {15'h0, got.pt});
        check("sb_pred_target", IF_ID_predicted_target,         got.ptgt);
    endtask

    task automatic step();
        cycle(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    endtask

    task automatic goto_pc(input logic [15:0] a);
        cycle(1'b0, 1'b1, 1'b1, a, 1'b0, 1'b0);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_addr"}, imem_addr, 16'h0000);
        check({tag, "_inst"}, IF_ID_pc_inst, 16'h0000);
        check({tag, "_pt"},   {15'h0, IF_ID_predicted_taken}, 16'h0000);
        check({tag, "_curr"}, IF_ID_pc_curr, 16'h0000);
        check({tag, "_tgt"},  IF_ID_predicted_target, 16'h0000);
    endtask

    logic [15:0] held_addr;

    initial begin
        rst_n = 1'b0; stall = 1'b0; update_PC = 1'b0; actual_taken = 1'b0;
        branch_target = 16'h0; wen_BTB = 1'b0; wen_BHT = 1'b0;
        hlt_addr = 16'h0001;
        model_reset();

        // Reset state
        #12;
        check_zero_outputs("rst");
        rst_n = 1'b1;

        // Sequential fetch
        step();
        check("seq_addr1", imem_addr, 16'h0002);
        check("seq_next1", IF_ID_pc_next, 16'h0002);
        step();
        check("seq_addr2", imem_addr, 16'h0004);
        check("seq_curr2", IF_ID_pc_curr, 16'h0002);

        // Train branch at 0x0010 -> 0x0040 (taken twice)
        goto_pc(16'h0010);
        step();
        check("trn_nopred", {15'h0, IF_ID_predicted_taken}, 16'h0000);
        cycle(1'b0, 1'b1, 1'b1, 16'h0040, 1'b1, 1'b1);
        goto_pc(16'h0010);
        step();
        cycle(1'b0, 1'b0, 1'b1, 16'h0040, 1'b1, 1'b1);
        goto_pc(16'h0010);
        step();
        check("trn_pt",   {15'h0, IF_ID_predicted_taken}, 16'h0001);
        check("trn_curr", IF_ID_pc_curr, 16'h0010);
        check("trn_tgt",  IF_ID_predicted_target, 16'h0040);
        check("trn_addr", imem_addr, 16'h0040);

        // Mispredict: resolved not taken, fall through to 0x0012 and flush
        cycle(1'b0, 1'b1, 1'b0, 16'h0040, 1'b0, 1'b0);
        check("mis_addr", imem_addr, 16'h0012);
        check("mis_inst", IF_ID_pc_inst, 16'h0000);

        // Stall beats redirect and training
        held_addr = imem_addr;
        cycle(1'b1, 1'b1, 1'b1, 16'h0080, 1'b1, 1'b1);
        check("stl_addr", imem_addr, held_addr);
        check("stl_inst", IF_ID_pc_inst, 16'h0000);
        step();
        check("stl_resume", imem_addr, 16'h0014);

        // Third taken training: counter saturates at 11
        goto_pc(16'h0010);
        step();
        cycle(1'b0, 1'b0, 1'b1, 16'h0040, 1'b1, 1'b1);
        goto_pc(16'h0010);
        step();
        check("sat_pt", {15'h0, IF_ID_predicted_taken}, 16'h0001);

        // Alias: 0x0030 shares the index, different tag -> no prediction
        goto_pc(16'h0030);
        step();
        check("alias_pt",   {15'h0, IF_ID_predicted_taken}, 16'h0000);
        check("alias_addr", imem_addr, 16'h0032);

        // Two not-taken trainings: 11 -> 10 (still taken) -> 01 (not taken)
        goto_pc(16'h0010);
        step();
        cycle(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1);
        goto_pc(16'h0010);
        step();
        check("dec1_pt", {15'h0, IF_ID_predicted_taken}, 16'h0001);
        cycle(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1);
        goto_pc(16'h0010);
        step();
        check("dec2_pt",   {15'h0, IF_ID_predicted_taken}, 16'h0000);
        check("dec2_addr", imem_addr, 16'h0012);

        // HLT holds the PC
        hlt_addr = 16'h0050;
        goto_pc(16'h0050);
        step();
        step();
        check("hlt_addr", imem_addr, 16'h0050);
        check("hlt_inst", IF_ID_pc_inst, 16'hF000);
        hlt_addr = 16'h0001;

        // PC + 2 wraps at 0xFFFE
        goto_pc(16'hFFFE);
        step();
        check("wrap_addr", imem_addr, 16'h0000);
        check("wrap_next", IF_ID_pc_next, 16'h0000);
        step();

        // Asynchronous reset mid-run
        #2;
        rst_n = 1'b0;
        #1;
        check_zero_outputs("arst");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("arst_addr", imem_addr, 16'h0002);
        check("arst_curr", IF_ID_pc_curr, 16'h0000);
        // Predictor was cleared: 0x0010 no longer predicts taken
        goto_pc(16'h0010);
        step();
        check("arst_bp", {15'h0, IF_ID_predicted_taken}, 16'h0000);

        check("sb_empty", 16'(sb.size()), 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
